// File: rtl/spi_slave_regs.sv
// SPI mode-0 register-file responder: 0x0A write / 0x0B read command, address, then data bytes.
// Define SPI_SLAVE_AUTOINC_EN for burst access (address advances after every data byte).
module spi_slave_regs #(
  parameter int         DEPTH = 16,
  parameter logic [7:0] DEVID = 8'hAD
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe,
  output logic       frame_active,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cmd_err,
  input  logic [7:0] reg_raddr,
  output logic [7:0] reg_rdata
);

  typedef enum logic [2:0] {
    PH_CMD, PH_WR_ADDR, PH_WR_DATA, PH_RD_ADDR, PH_RD_DATA, PH_IGNORE
  } phase_t;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  phase_t     r_phase, w_phase_next;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx_shift;
  logic [7:0] r_tx_shift, r_addr;
  logic       r_miso, r_frame_active, r_wr_strobe, r_cmd_err;
  logic [7:0] r_wr_addr, r_wr_data;
  logic [7:0] r_regs [1:DEPTH-1];

  logic [7:0] w_byte, w_next_addr, w_lookup_addr, w_lookup_data, w_rd_mux;
  logic       w_byte_done, w_wr_fire, w_cmd_bad, w_miso_oe;

  assign w_byte      = {r_rx_shift, mosi_i};
  assign w_byte_done = (r_bit_cnt == 3'd7);

`ifdef SPI_SLAVE_AUTOINC_EN
  assign w_next_addr = r_addr + 8'd1;
`else
  assign w_next_addr = r_addr;
`endif

  // cs_n high acts as a second asynchronous reset for all per-frame state.
  always_ff @(posedge sclk or posedge rst or posedge cs_n) begin
    if (rst)       r_phase <= PH_CMD;
    else if (cs_n) r_phase <= PH_CMD;
    else           r_phase <= w_phase_next;
  end

  // NOTE: every variable assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_phase_next = r_phase;
    if (w_byte_done) begin
      unique case (r_phase)
        PH_CMD:      w_phase_next = (w_byte == CMD_WRITE) ? PH_WR_ADDR :
                                    (w_byte == CMD_READ)  ? PH_RD_ADDR : PH_IGNORE;
        PH_WR_ADDR:  w_phase_next = PH_WR_DATA;
        PH_RD_ADDR:  w_phase_next = PH_RD_DATA;
        default:     w_phase_next = r_phase;
      endcase
    end
  end

  always_comb begin
    w_miso_oe = (r_phase == PH_RD_DATA) && !cs_n;
    w_wr_fire = w_byte_done && (r_phase == PH_WR_DATA);
    w_cmd_bad = w_byte_done && (r_phase == PH_CMD) &&
                (w_byte != CMD_WRITE) && (w_byte != CMD_READ);
  end

  always_comb begin
    w_lookup_addr = (r_phase == PH_RD_ADDR) ? w_byte : w_next_addr;
    w_lookup_data = (w_lookup_addr == 8'h00) ? DEVID : 8'h00;
    for (int i = 1; i < DEPTH; i++)
      if (w_lookup_addr == 8'(i)) w_lookup_data = r_regs[i];
  end

  always_comb begin
    w_rd_mux = (reg_raddr == 8'h00) ? DEVID : 8'h00;
    for (int i = 1; i < DEPTH; i++)
      if (reg_raddr == 8'(i)) w_rd_mux = r_regs[i];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sclk or posedge rst or posedge cs_n) begin
    if (rst) begin
      r_bit_cnt      <= '0;
      r_rx_shift     <= '0;
      r_tx_shift     <= '0;
      r_addr         <= '0;
      r_frame_active <= 1'b0;
      r_wr_strobe    <= 1'b0;
    end else if (cs_n) begin
      r_bit_cnt      <= '0;
      r_rx_shift     <= '0;
      r_frame_active <= 1'b0;
      r_wr_strobe    <= 1'b0;
    end else begin
      r_bit_cnt      <= r_bit_cnt + 3'd1;
      r_rx_shift     <= w_byte[6:0];
      r_frame_active <= 1'b1;
      r_wr_strobe    <= w_wr_fire;
      if (w_byte_done) begin
        unique case (r_phase)
          PH_WR_ADDR: r_addr <= w_byte;
          PH_WR_DATA: r_addr <= w_next_addr;
          PH_RD_ADDR: begin r_addr <= w_byte;      r_tx_shift <= w_lookup_data; end
          PH_RD_DATA: begin r_addr <= w_next_addr; r_tx_shift <= w_lookup_data; end
          default: ;
        endcase
      end else if (r_phase == PH_RD_DATA) begin
        // Pre-shift so tx_shift[7] always holds the bit for the coming falling edge.
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
    end
  end

  // NOTE: the register file is reset because reads must return 0x00 after rst; it survives frame aborts.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) r_regs[i] <= 8'h00;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_cmd_err <= 1'b0;
    end else if (!cs_n) begin
      if (w_wr_fire) begin
        for (int i = 1; i < DEPTH; i++)
          if (r_addr == 8'(i)) r_regs[i] <= w_byte;
        r_wr_addr <= r_addr;
        r_wr_data <= w_byte;
      end
      if (w_cmd_bad) r_cmd_err <= 1'b1;
    end
  end

  always_ff @(negedge sclk or posedge rst or posedge cs_n) begin
    if (rst)                       r_miso <= 1'b0;
    else if (cs_n)                 r_miso <= 1'b0;
    else if (r_phase == PH_RD_DATA) r_miso <= r_tx_shift[7];
    else                           r_miso <= 1'b0;
  end

  assign miso_o       = r_miso;
  assign miso_oe      = w_miso_oe;
  assign frame_active = r_frame_active;
  assign wr_strobe    = r_wr_strobe;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign cmd_err      = r_cmd_err;
  assign reg_rdata    = w_rd_mux;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: acts as a mode-0 SPI master and checks registers, strobes and MISO.
module tb_spi_slave_regs;

  logic       sclk, rst, cs_n, mosi_i;
  logic       miso_o, miso_oe, frame_active, wr_strobe, cmd_err;
  logic [7:0] wr_addr, wr_data, reg_raddr, reg_rdata;

  int tests_run = 0;
  int tests_failed = 0;
  int strobe_cnt = 0;
  int s0;
  logic [7:0] rx_b [5];
  logic [7:0] oe_b [5];
  logic       fa_seen;
  logic [7:0] saved;

  spi_slave_regs #(.DEPTH(16), .DEVID(8'hAD)) dut (
    .sclk(sclk), .rst(rst), .cs_n(cs_n), .mosi_i(mosi_i),
    .miso_o(miso_o), .miso_oe(miso_oe), .frame_active(frame_active),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_err(cmd_err), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata)
  );

  always @(posedge wr_strobe) strobe_cnt++;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [7:0] a, input logic [7:0] exp);
    reg_raddr = a;
    #1;
    check(tag, reg_rdata, exp);
  endtask

  // One master bit per iteration: MISO/OE sampled just before each rising edge.
  task automatic shift_byte(input logic [7:0] b, input int nbits,
                            output logic [7:0] rx, output logic [7:0] oe);
    rx = '0;
    oe = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi_i = b[7-i];
      #10;
      rx[7-i] = miso_o;
      oe[7-i] = miso_oe;
      sclk = 1'b1;
      #10;
      sclk = 1'b0;
    end
  endtask

  task automatic do_frame(input int n, input logic [7:0] b0, input logic [7:0] b1 = 8'h00,
                          input logic [7:0] b2 = 8'h00, input logic [7:0] b3 = 8'h00,
                          input logic [7:0] b4 = 8'h00);
    logic [7:0] tx [5];
    tx = '{b0, b1, b2, b3, b4};
    cs_n = 1'b0;
    #10;
    for (int i = 0; i < n; i++) shift_byte(tx[i], 8, rx_b[i], oe_b[i]);
    #5;
    fa_seen = frame_active;
    #5;
    cs_n = 1'b1;
    #20;
  endtask

  initial begin
    sclk = 1'b0; rst = 1'b0; cs_n = 1'b1; mosi_i = 1'b0; reg_raddr = 8'h00;
    #5 rst = 1'b1;
    #10 rst = 1'b0;
    #10;

    check("rst_miso", {7'b0, miso_o}, 8'h00);
    check("rst_oe", {7'b0, miso_oe}, 8'h00);
    check("rst_frame", {7'b0, frame_active}, 8'h00);
    check("rst_strobe", {7'b0, wr_strobe}, 8'h00);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_cmd_err", {7'b0, cmd_err}, 8'h00);
    check_reg("rst_devid", 8'h00, 8'hAD);
    check_reg("rst_reg5", 8'h05, 8'h00);

    // Device ID read
    do_frame(3, 8'h0B, 8'h00, 8'h00);
    check("devid_miso", rx_b[2], 8'hAD);
    check("devid_oe_cmd", oe_b[0], 8'h00);
    check("devid_oe_addr", oe_b[1], 8'h00);
    check("devid_oe_data", oe_b[2], 8'hFF);
    check("frame_active_in", {7'b0, fa_seen}, 8'h01);
    check("frame_active_out", {7'b0, frame_active}, 8'h00);
    check("oe_after_frame", {7'b0, miso_oe}, 8'h00);

    // Single write and read-back
    s0 = strobe_cnt;
    do_frame(3, 8'h0A, 8'h05, 8'h3C);
    check("wr1_strobes", 8'(strobe_cnt - s0), 8'd1);
    check("wr1_wr_addr", wr_addr, 8'h05);
    check("wr1_wr_data", wr_data, 8'h3C);
    check_reg("wr1_reg5", 8'h05, 8'h3C);
    do_frame(3, 8'h0B, 8'h05, 8'h00);
    check("rd1_miso", rx_b[2], 8'h3C);

    // Burst write then burst read
    s0 = strobe_cnt;
    do_frame(5, 8'h0A, 8'h02, 8'h11, 8'h22, 8'h33);
    check("burst_strobes", 8'(strobe_cnt - s0), 8'd3);
    check("burst_wr_data", wr_data, 8'h33);
`ifdef SPI_SLAVE_AUTOINC_EN
    check("burst_wr_addr", wr_addr, 8'h04);
    check_reg("burst_reg2", 8'h02, 8'h11);
    check_reg("burst_reg3", 8'h03, 8'h22);
    check_reg("burst_reg4", 8'h04, 8'h33);
    do_frame(5, 8'h0B, 8'h02, 8'h00, 8'h00, 8'h00);
    check("burst_rd0", rx_b[2], 8'h11);
    check("burst_rd1", rx_b[3], 8'h22);
    check("burst_rd2", rx_b[4], 8'h33);
`else
    check("burst_wr_addr", wr_addr, 8'h02);
    check_reg("burst_reg2", 8'h02, 8'h33);
    check_reg("burst_reg3", 8'h03, 8'h00);
    check_reg("burst_reg4", 8'h04, 8'h00);
    do_frame(5, 8'h0B, 8'h02, 8'h00, 8'h00, 8'h00);
    check("burst_rd0", rx_b[2], 8'h33);
    check("burst_rd1", rx_b[3], 8'h33);
    check("burst_rd2", rx_b[4], 8'h33);
`endif

    // Mid-byte abort leaves the register untouched
    do_frame(3, 8'h0A, 8'h07, 8'h5A);
    check_reg("abort_pre_reg7", 8'h07, 8'h5A);
    s0 = strobe_cnt;
    saved = wr_data;
    cs_n = 1'b0;
    #10;
    shift_byte(8'h0A, 8, rx_b[0], oe_b[0]);
    shift_byte(8'h07, 8, rx_b[1], oe_b[1]);
    shift_byte(8'hFF, 5, rx_b[2], oe_b[2]);
    #10 cs_n = 1'b1;
    #20;
    check_reg("abort_reg7", 8'h07, 8'h5A);
    check("abort_strobes", 8'(strobe_cnt - s0), 8'd0);
    check("abort_wr_data", wr_data, saved);
    check("abort_frame", {7'b0, frame_active}, 8'h00);
    do_frame(3, 8'h0B, 8'h07, 8'h00);
    check("abort_readback", rx_b[2], 8'h5A);

    // Unknown command: sticky error, MISO quiet, no write
    s0 = strobe_cnt;
    do_frame(4, 8'h55, 8'h0A, 8'h05, 8'hFF);
    check("badcmd_err", {7'b0, cmd_err}, 8'h01);
    check("badcmd_miso", rx_b[0] | rx_b[1] | rx_b[2] | rx_b[3], 8'h00);
    check("badcmd_oe", oe_b[0] | oe_b[1] | oe_b[2] | oe_b[3], 8'h00);
    check("badcmd_strobes", 8'(strobe_cnt - s0), 8'd0);
    check_reg("badcmd_reg5", 8'h05, 8'h3C);

    // Out-of-range and address-0 writes are dropped but still strobe
    s0 = strobe_cnt;
    do_frame(3, 8'h0A, 8'h20, 8'h99);
    check("oor_strobes", 8'(strobe_cnt - s0), 8'd1);
    check("oor_wr_addr", wr_addr, 8'h20);
    check("oor_wr_data", wr_data, 8'h99);
    check_reg("oor_rdata", 8'h20, 8'h00);
    check_reg("oor_reg5", 8'h05, 8'h3C);
    do_frame(3, 8'h0B, 8'h20, 8'h00);
    check("oor_read", rx_b[2], 8'h00);
    do_frame(3, 8'h0A, 8'h00, 8'h77);
    check_reg("addr0_ro", 8'h00, 8'hAD);
    check_reg("last_reg", 8'h0F, 8'h00);
    check("cmd_err_sticky", {7'b0, cmd_err}, 8'h01);

    // Reset during the 2nd data bit of a read
    cs_n = 1'b0;
    #10;
    shift_byte(8'h0B, 8, rx_b[0], oe_b[0]);
    shift_byte(8'h05, 8, rx_b[1], oe_b[1]);
    shift_byte(8'h00, 1, rx_b[2], oe_b[2]);
    mosi_i = 1'b0;
    #4;
    check("midrd_oe_before", {7'b0, miso_oe}, 8'h01);
    rst = 1'b1;
    #1;
    check("midrd_miso", {7'b0, miso_o}, 8'h00);
    check("midrd_oe", {7'b0, miso_oe}, 8'h00);
    check("midrd_cmd_err", {7'b0, cmd_err}, 8'h00);
    check("midrd_wr_addr", wr_addr, 8'h00);
    check_reg("midrd_reg5", 8'h05, 8'h00);
    check_reg("midrd_reg7", 8'h07, 8'h00);
    #5 rst = 1'b0;
    #5 cs_n = 1'b1;
    #20;
    s0 = strobe_cnt;
    do_frame(3, 8'h0A, 8'h03, 8'hC3);
    check("post_rst_strobes", 8'(strobe_cnt - s0), 8'd1);
    check_reg("post_rst_reg3", 8'h03, 8'hC3);
    do_frame(3, 8'h0B, 8'h03, 8'h00);
    check("post_rst_read", rx_b[2], 8'hC3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
